// File: rtl/bpred_pkg.sv
// -----------------------------------------------------------------------------
// bpred_pkg
// Shared types and helpers for the fetch-stage branch predictor.
//   btb_entry_t : one BTB line {valid, tag, target, jump_bit, ctr}
//   CTR_*       : 2-bit saturating counter encodings (>= CTR_WEAK_T predicts taken)
//   ctr_inc/dec : saturating counter steps
// No ports; imported by bpred_btb and fetch_bpred_stage.
// -----------------------------------------------------------------------------
package bpred_pkg;

  localparam int unsigned TAG_W = 30;

  localparam logic [1:0] CTR_MIN    = 2'b00;
  localparam logic [1:0] CTR_WEAK_T = 2'b10;
  localparam logic [1:0] CTR_MAX    = 2'b11;

  // Tag is stored right-aligned; the unused upper bits stay zero for any depth.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic             jump_bit;
    logic [1:0]       ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    if (c == CTR_MAX) begin
      ctr_inc = CTR_MAX;
    end else begin
      ctr_inc = c + 2'd1;
    end
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    if (c == CTR_MIN) begin
      ctr_dec = CTR_MIN;
    end else begin
      ctr_dec = c - 2'd1;
    end
  endfunction

endpackage

// File: rtl/fetch_bpred_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_bpred_stage_if
// EX-stage resolution bus feeding the fetch predictor.
//   ex_valid         EX holds a resolved control instruction
//   ex_is_branch     conditional branch
//   ex_is_jump       JAL/JALR
//   ex_pc            PC of the EX instruction
//   ex_taken         actual outcome (1 for jumps)
//   ex_target        actual target
//   ex_pred_taken    prediction carried with the instruction
//   ex_pred_target   predicted target carried with the instruction
// master: EX side (drives); slave: fetch stage (consumes).
// -----------------------------------------------------------------------------
interface fetch_bpred_stage_if;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;

  modport master (
    output ex_valid, ex_is_branch, ex_is_jump, ex_pc,
           ex_taken, ex_target, ex_pred_taken, ex_pred_target
  );

  modport slave (
    input  ex_valid, ex_is_branch, ex_is_jump, ex_pc,
           ex_taken, ex_target, ex_pred_taken, ex_pred_target
  );
endinterface

// File: rtl/bpred_btb.sv
// -----------------------------------------------------------------------------
// bpred_btb
// Direct-mapped branch target buffer with 2-bit counters.
//   clk, reset      clock, synchronous active-high reset (clears every line)
//   lk_pc           lookup PC (combinational read of pre-update contents)
//   lk_taken        hit & (jump_bit | ctr >= weakly-taken)
//   lk_target       stored target on hit, 0 on miss
//   up_en           a control instruction resolved this cycle
//   up_pc/up_taken/up_is_jump/up_target   resolution details, written at the edge
// -----------------------------------------------------------------------------
module bpred_btb
  import bpred_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lk_pc,
  output logic        lk_taken,
  output logic [31:0] lk_target,
  input  logic        up_en,
  input  logic [31:0] up_pc,
  input  logic        up_taken,
  input  logic        up_is_jump,
  input  logic [31:0] up_target
);

  localparam int unsigned IDX = $clog2(ENTRIES);

  btb_entry_t mem_q [ENTRIES];
  btb_entry_t mem_d [ENTRIES];

  logic [IDX-1:0] lk_idx_s;
  logic [IDX-1:0] up_idx_s;
  btb_entry_t     lk_entry_s;
  btb_entry_t     up_entry_s;
  logic           lk_hit_s;
  logic           up_hit_s;

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
    tag_of = TAG_W'(pc >> (IDX + 2));
  endfunction

  // Combinational lookup; a different tag at the same index is a plain miss.
  always_comb begin
    lk_idx_s   = lk_pc[IDX+1:2];
    lk_entry_s = mem_q[lk_idx_s];
    lk_hit_s   = lk_entry_s.valid & (lk_entry_s.tag == tag_of(lk_pc));
    if (lk_hit_s) begin
      lk_taken  = lk_entry_s.jump_bit | (lk_entry_s.ctr >= CTR_WEAK_T);
      lk_target = lk_entry_s.target;
    end else begin
      lk_taken  = 1'b0;
      lk_target = 32'h0000_0000;
    end
  end

  // Next contents: train on hit, allocate/replace on taken miss, ignore not-taken miss.
  always_comb begin
    mem_d      = mem_q;
    up_idx_s   = up_pc[IDX+1:2];
    up_entry_s = mem_q[up_idx_s];
    up_hit_s   = up_entry_s.valid & (up_entry_s.tag == tag_of(up_pc));
    if (up_en && up_hit_s) begin
      if (up_taken) begin
        up_entry_s.ctr    = ctr_inc(up_entry_s.ctr);
        up_entry_s.target = up_target;
      end else begin
        up_entry_s.ctr    = ctr_dec(up_entry_s.ctr);
      end
      mem_d[up_idx_s] = up_entry_s;
    end else if (up_en && up_taken) begin
      up_entry_s.valid    = 1'b1;
      up_entry_s.tag      = tag_of(up_pc);
      up_entry_s.target   = up_target;
      up_entry_s.jump_bit = up_is_jump;
      up_entry_s.ctr      = CTR_WEAK_T;
      mem_d[up_idx_s]     = up_entry_s;
    end else begin
      mem_d[up_idx_s] = mem_q[up_idx_s];
    end
  end

  // Storage array; reset invalidates and zeroes all lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/fetch_bpred_stage.sv
// -----------------------------------------------------------------------------
// fetch_bpred_stage
// IF stage with dynamic prediction: PC register, BTB lookup, mispredict detect
// against EX resolution, next-PC selection.
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_stall             hold PC (a redirect still wins)
//   o_imem_addr/i_imem_rdata   instruction memory (combinational read)
//   o_pc, o_inst        fetch PC and instruction to IF/ID
//   o_pred_taken/o_pred_target prediction for o_pc, carried down the pipe
//   ex                  EX resolution bus (fetch_bpred_stage_if.slave)
//   o_flush             mispredict: flush IF/ID and ID/EX this cycle
//   o_mispred           o_flush for conditional branches only
// Optional (macro BPRED_PERF_EN): o_ctrl_cnt, o_mispred_cnt saturating counters.
// -----------------------------------------------------------------------------
module fetch_bpred_stage
  import bpred_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_stall,
  output logic [31:0]          o_imem_addr,
  input  logic [31:0]          i_imem_rdata,
  output logic [31:0]          o_pc,
  output logic [31:0]          o_inst,
  output logic                 o_pred_taken,
  output logic [31:0]          o_pred_target,
  fetch_bpred_stage_if.slave   ex,
  output logic                 o_flush,
  output logic                 o_mispred
`ifdef BPRED_PERF_EN
  ,
  output logic [31:0]          o_ctrl_cnt,
  output logic [31:0]          o_mispred_cnt
`endif
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        pred_taken_s;
  logic [31:0] pred_target_s;
  logic        ex_ctrl_s;
  logic        mispred_s;

  bpred_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk        (i_clk),
    .reset      (i_reset),
    .lk_pc      (pc_q),
    .lk_taken   (pred_taken_s),
    .lk_target  (pred_target_s),
    .up_en      (ex_ctrl_s),
    .up_pc      (ex.ex_pc),
    .up_taken   (ex.ex_taken),
    .up_is_jump (ex.ex_is_jump),
    .up_target  (ex.ex_target)
  );

  // Mispredict: wrong direction, or right direction but wrong target.
  always_comb begin
    ex_ctrl_s = ex.ex_valid & (ex.ex_is_branch | ex.ex_is_jump);
    mispred_s = ex_ctrl_s &
                ((ex.ex_taken != ex.ex_pred_taken) |
                 (ex.ex_taken & (ex.ex_target != ex.ex_pred_target)));
  end

  // Next PC: redirect > stall > prediction > sequential.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (mispred_s) begin
      if (ex.ex_taken) begin
        pc_d = ex.ex_target;
      end else begin
        pc_d = ex.ex_pc + 32'd4;
      end
    end else if (i_stall) begin
      pc_d = pc_q;
    end else if (pred_taken_s) begin
      pc_d = pred_target_s;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // PC register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Output drive.
  always_comb begin
    o_pc          = pc_q;
    o_imem_addr   = pc_q;
    o_inst        = i_imem_rdata;
    o_pred_taken  = pred_taken_s;
    o_pred_target = pred_target_s;
    o_flush       = mispred_s;
    o_mispred     = mispred_s & ex.ex_is_branch;
  end

`ifdef BPRED_PERF_EN
  logic [31:0] ctrl_cnt_q;
  logic [31:0] ctrl_cnt_d;
  logic [31:0] mispred_cnt_q;
  logic [31:0] mispred_cnt_d;

  // Saturating event counters.
  always_comb begin
    if (ex_ctrl_s && (ctrl_cnt_q != 32'hFFFF_FFFF)) begin
      ctrl_cnt_d = ctrl_cnt_q + 32'd1;
    end else begin
      ctrl_cnt_d = ctrl_cnt_q;
    end
    if (mispred_s && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end else begin
      mispred_cnt_d = mispred_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ctrl_cnt_q    <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      ctrl_cnt_q    <= ctrl_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_ctrl_cnt    = ctrl_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_bpred_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_bpred_stage
// Directed scenarios with literal expectations, plus a behavioural predictor
// model compared against the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_bpred_stage;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_stall;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        o_flush;
  logic        o_mispred;
`ifdef BPRED_PERF_EN
  logic [31:0] o_ctrl_cnt;
  logic [31:0] o_mispred_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_bpred_stage_if ex_if ();

  // Instruction memory: word derived from its address.
  assign i_imem_rdata = {o_imem_addr[15:0], ~o_imem_addr[15:0]};

  fetch_bpred_stage #(.BTB_ENTRIES(16), .RESET_PC(32'h0000_0000)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_stall       (i_stall),
    .o_imem_addr   (o_imem_addr),
    .i_imem_rdata  (i_imem_rdata),
    .o_pc          (o_pc),
    .o_inst        (o_inst),
    .o_pred_taken  (o_pred_taken),
    .o_pred_target (o_pred_target),
    .ex            (ex_if.slave),
    .o_flush       (o_flush),
    .o_mispred     (o_mispred)
`ifdef BPRED_PERF_EN
    ,
    .o_ctrl_cnt    (o_ctrl_cnt),
    .o_mispred_cnt (o_mispred_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_started = 1'b0;
  logic [31:0] m_pc;
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  bit          m_jump  [16];
  int          m_ctr   [16];
  int unsigned m_ctrl_cnt;
  int unsigned m_mis_cnt;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == int'(pc / 32'd64));
  endfunction

  function automatic bit m_ptaken(input logic [31:0] pc);
    return m_hit(pc) && (m_jump[m_idx(pc)] || m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
    return m_hit(pc) ? m_tgt[m_idx(pc)] : 32'h0;
  endfunction

  function automatic bit m_ctrl();
    return ex_if.ex_valid && (ex_if.ex_is_branch || ex_if.ex_is_jump);
  endfunction

  function automatic bit m_flush();
    if (!m_ctrl()) return 1'b0;
    if (ex_if.ex_taken != ex_if.ex_pred_taken) return 1'b1;
    return ex_if.ex_taken && (ex_if.ex_target != ex_if.ex_pred_target);
  endfunction

  // Compare the DUT against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    logic [31:0] npc;
    int          k;
    if (m_started) begin
      check("pc",          o_pc,          m_pc);
      check("imem_addr",   o_imem_addr,   m_pc);
      check("inst",        o_inst,        {m_pc[15:0], ~m_pc[15:0]});
      check("pred_taken",  {31'd0, o_pred_taken}, {31'd0, m_ptaken(m_pc)});
      check("pred_target", o_pred_target, m_ptarget(m_pc));
      check("flush",       {31'd0, o_flush},   {31'd0, m_flush()});
      check("mispred",     {31'd0, o_mispred}, {31'd0, m_flush() && ex_if.ex_is_branch});
`ifdef BPRED_PERF_EN
      check("ctrl_cnt",    o_ctrl_cnt,    m_ctrl_cnt);
      check("mispred_cnt", o_mispred_cnt, m_mis_cnt);
`endif
    end
    if (i_reset) begin
      m_pc = 32'h0;
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 32'h0; m_jump[i] = 1'b0; m_ctr[i] = 0;
      end
      m_ctrl_cnt = 0;
      m_mis_cnt  = 0;
      m_started  = 1'b1;
    end else if (m_started) begin
      if (m_flush()) npc = ex_if.ex_taken ? ex_if.ex_target : ex_if.ex_pc + 32'd4;
      else if (i_stall) npc = m_pc;
      else if (m_ptaken(m_pc)) npc = m_ptarget(m_pc);
      else npc = m_pc + 32'd4;
      if (m_ctrl()) begin
        k = m_idx(ex_if.ex_pc);
        if (m_ctrl_cnt != 32'hFFFF_FFFF) m_ctrl_cnt++;
        if (m_flush() && m_mis_cnt != 32'hFFFF_FFFF) m_mis_cnt++;
        if (m_hit(ex_if.ex_pc)) begin
          if (ex_if.ex_taken) begin
            m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
            m_tgt[k] = ex_if.ex_target;
          end else begin
            m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
          end
        end else if (ex_if.ex_taken) begin
          m_valid[k] = 1'b1;
          m_tag[k]   = ex_if.ex_pc / 32'd64;
          m_tgt[k]   = ex_if.ex_target;
          m_jump[k]  = ex_if.ex_is_jump;
          m_ctr[k]   = 2;
        end
      end
      m_pc = npc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    ex_if.ex_valid       = 1'b0;
    ex_if.ex_is_branch   = 1'b0;
    ex_if.ex_is_jump     = 1'b0;
    ex_if.ex_pc          = 32'h0;
    ex_if.ex_taken       = 1'b0;
    ex_if.ex_target      = 32'h0;
    ex_if.ex_pred_taken  = 1'b0;
    ex_if.ex_pred_target = 32'h0;
  endtask

  task automatic set_ex(input bit br, input bit jmp, input logic [31:0] pc, input bit tk,
                        input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    ex_if.ex_valid       = 1'b1;
    ex_if.ex_is_branch   = br;
    ex_if.ex_is_jump     = jmp;
    ex_if.ex_pc          = pc;
    ex_if.ex_taken       = tk;
    ex_if.ex_target      = tgt;
    ex_if.ex_pred_taken  = ptk;
    ex_if.ex_pred_target = ptgt;
    #1;
  endtask

  // Steer fetch to p through a not-taken mispredict of a branch at p-4.
  task automatic redirect(input logic [31:0] p);
    set_ex(1'b1, 1'b0, p - 32'd4, 1'b0, 32'h0, 1'b1, p);
    step();
    idle_ex();
    check("redirect", o_pc, p);
  endtask

  task automatic wait_pc(input logic [31:0] p, input int budget);
    int n = 0;
    while (o_pc !== p && n < budget) begin
      step();
      n++;
    end
    check("wait_pc", o_pc, p);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    i_reset = 1'b1;
    i_stall = 1'b0;
    idle_ex();

    // Reset and sequential fetch
    step(); step();
    check("rst_pc", o_pc, 32'h0);
    check("rst_pred", {31'd0, o_pred_taken}, 32'd0);
    check("rst_ptgt", o_pred_target, 32'h0);
    check("rst_flush", {31'd0, o_flush}, 32'd0);
    i_reset = 1'b0;
    step(); check("seq4", o_pc, 32'h4);
    step(); check("seq8", o_pc, 32'h8);
    step(); check("seqC", o_pc, 32'hC);

    // Loop branch at 0x10 -> 0x04
    set_ex(1'b1, 1'b0, 32'h10, 1'b1, 32'h4, 1'b0, 32'h0);
    check("loop_flush", {31'd0, o_flush}, 32'd1);
    check("loop_mispred", {31'd0, o_mispred}, 32'd1);
    step(); idle_ex();
    check("loop_redir", o_pc, 32'h4);
    wait_pc(32'h10, 8);
    check("loop_pred", {31'd0, o_pred_taken}, 32'd1);
    check("loop_ptgt", o_pred_target, 32'h4);
    set_ex(1'b1, 1'b0, 32'h10, 1'b1, 32'h4, 1'b1, 32'h4);
    check("loop_noflush", {31'd0, o_flush}, 32'd0);
    step(); idle_ex();
    check("loop_follow", o_pc, 32'h4);

    // Counter: third taken saturates, then two not-taken resolves
    set_ex(1'b1, 1'b0, 32'h10, 1'b1, 32'h4, 1'b1, 32'h4);
    step(); idle_ex();
    set_ex(1'b1, 1'b0, 32'h10, 1'b0, 32'h4, 1'b1, 32'h4);
    check("ctr_n1_flush", {31'd0, o_flush}, 32'd1);
    step(); idle_ex();
    check("ctr_n1_pc", o_pc, 32'h14);
    redirect(32'h10);
    check("ctr_still_t", {31'd0, o_pred_taken}, 32'd1);
    set_ex(1'b1, 1'b0, 32'h10, 1'b0, 32'h4, 1'b1, 32'h4);
    check("ctr_n2_flush", {31'd0, o_flush}, 32'd1);
    step(); idle_ex();
    check("ctr_n2_pc", o_pc, 32'h14);
    redirect(32'h10);
    check("ctr_now_nt", {31'd0, o_pred_taken}, 32'd0);

    // Stall holds PC; a redirect during stall wins
    wait_pc(32'h20, 8);
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", o_pc, 32'h20);
    end
    set_ex(1'b1, 1'b0, 32'h1C, 1'b1, 32'h40, 1'b0, 32'h0);
    step(); idle_ex();
    check("stall_redir", o_pc, 32'h40);
    i_stall = 1'b0;

    // Alias: 0x50 shares index with 0x10
    redirect(32'h50);
    check("alias_miss", {31'd0, o_pred_taken}, 32'd0);
    set_ex(1'b1, 1'b0, 32'h50, 1'b1, 32'h80, 1'b0, 32'h0);
    step(); idle_ex();
    check("alias_redir", o_pc, 32'h80);
    redirect(32'h10);
    check("alias_evict", {31'd0, o_pred_taken}, 32'd0);
    check("alias_ptgt", o_pred_target, 32'h0);

    // JALR at 0x30: target changes 0x100 -> 0x200
    set_ex(1'b0, 1'b1, 32'h30, 1'b1, 32'h100, 1'b0, 32'h0);
    check("jalr_flush", {31'd0, o_flush}, 32'd1);
    check("jalr_nomis", {31'd0, o_mispred}, 32'd0);
    step(); idle_ex();
    check("jalr_pc1", o_pc, 32'h100);
    redirect(32'h30);
    check("jalr_pred1", {31'd0, o_pred_taken}, 32'd1);
    check("jalr_ptgt1", o_pred_target, 32'h100);
    set_ex(1'b0, 1'b1, 32'h30, 1'b1, 32'h200, 1'b1, 32'h100);
    check("jalr_tflush", {31'd0, o_flush}, 32'd1);
    step(); idle_ex();
    check("jalr_pc2", o_pc, 32'h200);
    redirect(32'h30);
    check("jalr_ptgt2", o_pred_target, 32'h200);

    // PC wrap
    redirect(32'hFFFF_FFFC);
    step();
    check("wrap", o_pc, 32'h0);

    // Reset mid-operation beats a concurrent redirect and clears the BTB
    step();
    i_reset = 1'b1;
    set_ex(1'b1, 1'b0, 32'h8, 1'b1, 32'h40, 1'b0, 32'h0);
    step(); idle_ex();
    i_reset = 1'b0;
    check("midrst_pc", o_pc, 32'h0);
    redirect(32'h30);
    check("midrst_btb", {31'd0, o_pred_taken}, 32'd0);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
